// File: rtl/pattern_seq.sv
`timescale 1ns/1ps
// pattern_seq: 16-step, three-channel note sequencer.
//
// A 16 x 3*(NOTE_W+1) pattern memory holds one entry per step:
// {en3, note3, en2, note2, en1, note1}, MSB first. While running, a new step
// is applied every STEP_TICKS clocks and the sequence wraps after loop_last.
//
// Ports
//   clk50mhz     in   system clock, rising edge
//   rst          in   synchronous active-high reset (clears state and memory)
//   play         in   level: 1 = run, 0 = pause / idle
//   restart      in   one-cycle pulse: return to step 0
//   loop_last    in   [3:0] last step index before wrapping to 0
//   wr_en        in   pattern write strobe
//   wr_addr      in   [3:0] step entry to write
//   wr_data      in   step entry {en3, note3, en2, note2, en1, note1}
//   note_ch1..3  out  [NOTE_W-1:0] registered notes (square 1, square 2, triangle)
//   en_ch1..3    out  registered channel enables
//   step         out  [3:0] index of the step currently applied
//   step_strobe  out  one-cycle pulse when a step is applied
//   beat_led     out  toggles on every step apply
module pattern_seq #(
    parameter int STEP_TICKS = 6000000,
    parameter int NOTE_W     = 6
) (
    input  logic                      clk50mhz,
    input  logic                      rst,
    input  logic                      play,
    input  logic                      restart,
    input  logic [3:0]                loop_last,
    input  logic                      wr_en,
    input  logic [3:0]                wr_addr,
    input  logic [3*(NOTE_W+1)-1:0]   wr_data,
    output logic [NOTE_W-1:0]         note_ch1,
    output logic [NOTE_W-1:0]         note_ch2,
    output logic [NOTE_W-1:0]         note_ch3,
    output logic                      en_ch1,
    output logic                      en_ch2,
    output logic                      en_ch3,
    output logic [3:0]                step,
    output logic                      step_strobe,
    output logic                      beat_led
);

    localparam int ENTRY_W = 3 * (NOTE_W + 1);
    localparam int TICK_W  = $clog2(STEP_TICKS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_TICKS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    logic [ENTRY_W-1:0] mem [16];
    logic [1:0]         state, state_nxt;
    logic [TICK_W-1:0]  tick, tick_nxt;

    logic               load;        // apply step load_idx on this edge
    logic [3:0]         load_idx;
    logic               en_restore;  // resume from pause: enables from current entry
    logic               en_clear;    // force all enables low
    logic               step_clr;    // restart into idle: step back to 0
    logic [3:0]         rd_idx;
    logic [ENTRY_W-1:0] entry;

    function automatic logic [NOTE_W-1:0] note_of(input logic [ENTRY_W-1:0] e, input int ch);
        return e[ch*(NOTE_W+1) +: NOTE_W];
    endfunction

    function automatic logic en_of(input logic [ENTRY_W-1:0] e, input int ch);
        return e[ch*(NOTE_W+1) + NOTE_W];
    endfunction

    // A zero note means "keep sounding the previous note".
    function automatic logic [NOTE_W-1:0] next_note(input logic [NOTE_W-1:0] cur,
                                                    input logic [NOTE_W-1:0] nw);
        return (nw != '0) ? nw : cur;
    endfunction

    // Asynchronous read: a write landing on the same edge as a load is not
    // seen until the next visit to that step.
    assign rd_idx = load ? load_idx : step;
    assign entry  = mem[rd_idx];

    always_comb begin
        state_nxt  = state;
        tick_nxt   = tick;
        load       = 1'b0;
        load_idx   = 4'd0;
        en_restore = 1'b0;
        en_clear   = 1'b0;
        step_clr   = 1'b0;
        if (restart) begin
            tick_nxt = '0;
            if (play) begin
                state_nxt = RUN;
                load      = 1'b1;
            end else begin
                state_nxt = IDLE;
                en_clear  = 1'b1;
                step_clr  = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (play) begin
                        state_nxt = RUN;
                        tick_nxt  = '0;
                        load      = 1'b1;
                    end else begin
                        en_clear = 1'b1;
                    end
                end
                RUN: begin
                    if (!play) begin
                        state_nxt = PAUSE;
                        en_clear  = 1'b1;
                    end else if (tick == TICK_LAST) begin
                        tick_nxt = '0;
                        load     = 1'b1;
                        // >= so a loop_last lowered below the current step
                        // wraps at the very next boundary.
                        load_idx = (step >= loop_last) ? 4'd0 : step + 4'd1;
                    end else begin
                        tick_nxt = tick + TICK_W'(1);
                    end
                end
                PAUSE: begin
                    if (play) begin
                        state_nxt  = RUN;
                        en_restore = 1'b1;
                    end else begin
                        en_clear = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    en_clear  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk50mhz) begin
        if (rst) begin
            state       <= IDLE;
            tick        <= '0;
            step        <= 4'd0;
            note_ch1    <= '0;
            note_ch2    <= '0;
            note_ch3    <= '0;
            en_ch1      <= 1'b0;
            en_ch2      <= 1'b0;
            en_ch3      <= 1'b0;
            step_strobe <= 1'b0;
            beat_led    <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state       <= state_nxt;
            tick        <= tick_nxt;
            step_strobe <= load;
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            if (load) begin
                step     <= load_idx;
                beat_led <= ~beat_led;
                note_ch1 <= next_note(note_ch1, note_of(entry, 0));
                note_ch2 <= next_note(note_ch2, note_of(entry, 1));
                note_ch3 <= next_note(note_ch3, note_of(entry, 2));
                en_ch1   <= en_of(entry, 0);
                en_ch2   <= en_of(entry, 1);
                en_ch3   <= en_of(entry, 2);
            end else if (en_restore) begin
                en_ch1 <= en_of(entry, 0);
                en_ch2 <= en_of(entry, 1);
                en_ch3 <= en_of(entry, 2);
            end else if (en_clear) begin
                en_ch1 <= 1'b0;
                en_ch2 <= 1'b0;
                en_ch3 <= 1'b0;
            end
            if (step_clr) begin
                step <= 4'd0;
            end
        end
    end

endmodule
